// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx_in, samples each bit near its midpoint and
// presents good bytes on a valid/read handshake with framing-error and overrun flags.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_in,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [2:0]             idx_q;
  logic [7:0]             shift_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  // Synchronizer resets to the idle (high) line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rx_valid && rd_en) begin
        rx_valid <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q <= StStart;
            cnt_q   <= '0;
            busy    <= 1'b1;
          end
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              state_q <= StData;
              idx_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == BitLast) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s;
            idx_q          <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= StStop;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == BitLast) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= StIdle;
              busy    <= 1'b0;
              // A consume in the same cycle frees the slot, so the new byte still loads.
              if (!rx_valid || rd_en) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state_q   <= StBreak;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StBreak: begin
          if (rx_s) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the inbound counterpart to the board's UART transmitter.
- Takes the asynchronous serial line from the host/PC and rebuilds bytes, LSB first.
- Presents each byte on a valid/read handshake to downstream logic (command decoder / result buffer).
- Detects false starts, framing errors and overrun.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200); must be >= 8.
- SYNC_STAGES, 2, metastability flops on rx_in; must be >= 2.

Ports:
- clk  input  1  system clock, 100 MHz.
- rstn  input  1  synchronous, active-low reset.
- rx_in  input  1  asynchronous serial line; idle high.
- rd_en  input  1  downstream consumes rx_data; meaningful only while rx_valid=1.
- rx_data  output  8  last good received byte; stable while rx_valid=1.
- rx_valid  output  1  byte available; held until consumed.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- overrun  output  1  sticky; set when a good byte completes while rx_valid=1.
- busy  output  1  high in every state except IDLE.

Behaviour:
Reset and clocking
- Reset value of every output is 0: rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0.
- On reset: state=IDLE, counters=0, synchronizer flops=1.
- Reset mid-frame aborts the frame with no output activity.

Synchronizer and counters
- rx_in passes through SYNC_STAGES flops; rx_s is the final stage. All decisions use rx_s only.
- Bit counter width is clog2(CLKS_PER_BIT). Bit index is 3 bits.
- HALF = CLKS_PER_BIT/2, integer truncation.

State machine (IDLE, START, DATA, STOP, BREAK)
- IDLE: rx_s=0 -> START with counter cleared.
- START: count to HALF-1, then sample rx_s.
  - rx_s=1: false start -> IDLE, no flags.
  - rx_s=0: -> DATA, counter cleared, index=0.
- DATA: after each CLKS_PER_BIT cycles, sample rx_s into shift[index] (LSB first); index++. After index 7 is sampled -> STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - rx_s=1: good frame -> IDLE.
  - rx_s=0: frame_err pulses for exactly 1 cycle; byte discarded -> BREAK.
- BREAK: wait for rx_s=1, then -> IDLE. Covers a line held low or a break condition; no new start is detected until the line returns high.
- Result: every sample lands at mid-bit ±1 cycle.

Output handshake
- Good stop sample at cycle N, rx_valid=0: rx_data<=shift and rx_valid<=1, both visible at N+1.
- Good stop sample at cycle N, rx_valid=1: new byte dropped, rx_data unchanged, overrun<=1 at N+1.
- overrun clears only on reset.
- rx_valid=1 and rd_en=1 in the same cycle: rx_valid=0 next cycle.
- Same cycle as a good stop sample with rx_valid=1 and rd_en=1: the consume wins and the new byte loads. rx_valid stays 1, rx_data updates, no overrun.
- rd_en while rx_valid=0 is ignored.

Timing
- Synchronizer adds SYNC_STAGES cycles.
- End-to-end: the rx_in falling edge of the start bit to rx_valid is about SYNC_STAGES + HALF + 9*CLKS_PER_BIT + 1 cycles.
- A start bit arriving directly after the stop sample (IDLE re-entry) is accepted with no gap cycle.

Test Plan:
(Bench uses CLKS_PER_BIT=16.)
- Good byte: drive 0x55 as 8N1 at 16 clk/bit -> rx_valid rises once, rx_data=0x55, frame_err=0. Pulse rd_en -> rx_valid=0 next cycle.
- Back-to-back bytes: send 0xA5 then 0x3C with no idle gap, rd_en pulsed after each -> two valid events carrying 0xA5 and 0x3C, overrun=0.
- False start and glitch: drive a 3-cycle low pulse on rx_in -> returns to IDLE, rx_valid=0, frame_err=0, busy high for about HALF+SYNC cycles only.
- Framing error: send 0xF0 with stop bit 0 and hold the line low 40 cycles -> frame_err one-cycle pulse, rx_valid=0, busy stays 1 until the line goes high. A following good 0x12 is then received correctly.
- Overrun: send 0x11 without rd_en, then 0x22 -> rx_data stays 0x11, overrun=1 after the second stop sample. Apply rd_en, then send 0x33 -> rx_data=0x33, overrun remains 1.
- Reset mid-frame: assert rstn=0 during data bit 4 of 0x99 -> all outputs 0 next cycle, busy=0. After release, a good 0x66 is received correctly.
